// File: rtl/state_unloader.sv
// state_unloader: walks the 64x25 state memory one page per clock and reassembles
// the flat lane-major/slice-minor state word, then offers it on a valid/ready handshake.
module state_unloader #(
    parameter int PAGES  = 64,
    parameter int LANE_W = 25,
    parameter int ADDR_W = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    output logic [ADDR_W-1:0]         page_o,
    input  logic [LANE_W-1:0]         rd_data_i,
    output logic                      busy_o,
    output logic [PAGES*LANE_W-1:0]   out_data_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i
);
    typedef enum logic [1:0] {IDLE, READ, HOLD} state_e;
    state_e                           state_q;
    logic [ADDR_W-1:0]                cnt_q;
    logic                             busy_q, valid_q;
    // Row i holds lane bit i of every slice, so flat bit PAGES*i+z lands at [i][z].
    logic [LANE_W-1:0][PAGES-1:0]     shadow_q, shadow_d, data_q;
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < LANE_W; i++) shadow_d[i][cnt_q] = rd_data_i[i];
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            shadow_q <= '0;
            data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_q <= READ;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
                READ: begin
                    shadow_q <= shadow_d;
                    cnt_q    <= cnt_q + 1'b1;
                    // Last slice wraps cnt back to 0, which parks page at 0 for HOLD.
                    if (cnt_q == ADDR_W'(PAGES - 1)) begin
                        data_q  <= shadow_d;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= HOLD;
                    end
                end
                HOLD: if (out_ready_i) begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign page_o      = cnt_q;
    assign busy_o      = busy_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
endmodule

// File: tb/tb_state_unloader.sv
// tb_state_unloader: directed scoreboard bench for state_unloader with a behavioural
// 64x25 memory answering the page address combinationally.
module tb_state_unloader;
    localparam int W = 1600;
    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b1;
    logic [5:0]    page;
    logic [24:0]   rd_data;
    logic          busy, out_valid;
    logic [W-1:0]  out_data;
    logic [24:0]   mem [64];
    logic [W-1:0]  sb [$];
    logic [W-1:0]  v, e, held;
    int            passed = 0, total = 0, bad;
    state_unloader dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .page_o(page), .rd_data_i(rd_data),
        .busy_o(busy), .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready)
    );
    always #5 clk = ~clk;
    assign rd_data = mem[page];
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask
    task automatic load_word(input logic [W-1:0] w);
        for (int z = 0; z < 64; z++)
            for (int i = 0; i < 25; i++) mem[z][i] = w[64*i+z];
    endtask
    // mid: cycle index at which a stray start is pulsed; abort_pg: page at which reset hits.
    task automatic unload(input string tag, input logic [W-1:0] exp, input int mid, input int abort_pg);
        int lat, bcnt = 0, perr = 0;
        sb.push_back(exp);
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (busy) begin
                if (page !== 6'(bcnt)) perr++;
                bcnt++;
            end
            if (abort_pg >= 0 && busy && page == 6'(abort_pg)) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                chk({tag, " abort busy"}, busy, 1'b0);
                chk({tag, " abort valid"}, out_valid, 1'b0);
                chk({tag, " abort page"}, page, 6'd0);
                void'(sb.pop_front());
                return;
            end
            start = (lat == mid);
            step();
            start = 1'b0;
            lat++;
        end
        chk({tag, " latency"}, lat, 65);
        chk({tag, " busy cycles"}, bcnt, 64);
        chk({tag, " page order"}, perr, 0);
        chk({tag, " data"}, out_data, sb.pop_front());
        if (out_ready) begin
            held = out_data;
            step();
            chk({tag, " valid drop"}, out_valid, 1'b0);
            chk({tag, " busy idle"}, busy, 1'b0);
            chk({tag, " data kept"}, out_data, held);
        end
    endtask
    initial begin
        for (int z = 0; z < 64; z++) mem[z] = '0;
        repeat (3) step();
        chk("reset busy", busy, 1'b0);
        chk("reset valid", out_valid, 1'b0);
        chk("reset page", page, 6'd0);
        chk("reset data", out_data, '0);
        rst_n = 1'b1;
        step();
        e = '0;
        for (int z = 0; z < 64; z++) begin
            mem[z] = 25'(z);
            for (int i = 0; i < 6; i++) e[64*i+z] = z[i];
        end
        unload("index", e, -1, -1);
        for (int k = 0; k < 50; k++) v[32*k +: 32] = $urandom;
        load_word(v);
        unload("random", v, -1, -1);
        load_word({W{1'b1}});
        unload("ones", {W{1'b1}}, -1, -1);
        v = {200{8'hA5}};
        load_word(v);
        out_ready = 1'b0;
        unload("a5 hold", v, -1, -1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            start = (k == 3);
            step();
            start = 1'b0;
            if (!out_valid || busy || out_data !== v) bad++;
        end
        chk("backpressure stable", bad, 0);
        out_ready = 1'b1;
        step();
        chk("backpressure release", out_valid, 1'b0);
        step();
        chk("no restart from hold", busy, 1'b0);
        e = ~v;
        load_word(e);
        unload("start in read", e, 30, -1);
        repeat (3) step();
        chk("single completion", out_valid, 1'b0);
        chk("no restart from read", busy, 1'b0);
        for (int k = 0; k < 50; k++) v[32*k +: 32] = $urandom;
        load_word(v);
        unload("abort", v, -1, 40);
        for (int k = 0; k < 50; k++) e[32*k +: 32] = $urandom;
        load_word(e);
        unload("after abort", e, -1, -1);
        chk("scoreboard empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
